polar_arith: RTL and testbench

//  Downstream stage of the rect-to-polar converter: takes two operands in polar form (modulus, angle)
//  and computes their complex product or quotient entirely in the polar domain.

---
 rtl/polar_arith_pkg.sv | 37 +++
 rtl/polar_arith_if.sv | 27 ++
 rtl/polar_arith_seq_muldiv.sv | 86 ++++++++
 rtl/polar_arith.sv | 134 +++++++++++++
 tb/tb_polar_arith.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/polar_arith_pkg.sv
// Shared widths, angle constants, opcodes and FSM encoding for the polar
// multiply/divide stage.
package polar_arith_pkg;

  localparam int MOD_W    = 32;
  localparam int ANG_W    = 32;
  localparam int ANG_FRAC = 22;

  // Half and full turn in the angle fixed-point format; one guard bit so the
  // full turn and the unwrapped sum/difference are both representable.
  localparam logic signed [ANG_W:0] DEG180 = 33'sd180 <<< ANG_FRAC;
  localparam logic signed [ANG_W:0] DEG360 = 33'sd360 <<< ANG_FRAC;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int N_MUL = 32;
  localparam int N_DIV = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Fold an unwrapped sum in [-360,360) back into [-180,180).
  function automatic logic [ANG_W-1:0] ang_wrap(input logic signed [ANG_W:0] s);
    logic signed [ANG_W:0] r;
    r = s;
    if (s >= DEG180)
      r = s - DEG360;
    else if (s < -DEG180)
      r = s + DEG360;
    return r[ANG_W-1:0];
  endfunction

endpackage

// File: rtl/polar_arith_if.sv
// Request/result bundle between the polar operand source and polar_arith.
interface polar_arith_if;
  import polar_arith_pkg::*;

  logic             start;
  logic             op;
  logic [MOD_W-1:0] mod_a;
  logic [ANG_W-1:0] ang_a;
  logic [MOD_W-1:0] mod_b;
  logic [ANG_W-1:0] ang_b;
  logic             busy;
  logic             done;
  logic [MOD_W-1:0] mod_out;
  logic [ANG_W-1:0] ang_out;
  logic             ovf;
  logic             div_zero;

  modport master (
    output start, op, mod_a, ang_a, mod_b, ang_b,
    input  busy, done, mod_out, ang_out, ovf, div_zero
  );

  modport slave (
    input  start, op, mod_a, ang_a, mod_b, ang_b,
    output busy, done, mod_out, ang_out, ovf, div_zero
  );
endinterface

// File: rtl/polar_arith_seq_muldiv.sv
// Iterative 32x32 shift-add multiply and 48/32 restoring divide, one step per
// cycle. load_i primes the datapath, step_i advances it, last_o flags the
// final step for the selected operation.
module seq_muldiv
  import polar_arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        last_o,
  output logic [63:0] res_o
);

  logic        op_q,  op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;   // product (mul) or quotient shift register (div)
  logic [63:0] opa_q, opa_d;   // shifted multiplicand (mul) or dividend (div)
  logic [31:0] opb_q, opb_d;   // multiplier (mul) or divisor (div)
  logic [31:0] rem_q, rem_d;   // partial remainder, always < divisor

  logic [32:0] rem_sh;
  logic [33:0] rem_diff;
  logic        q_bit;

  // Restoring divide trial subtraction: bring in the next dividend bit.
  assign rem_sh   = {rem_q, opa_q[47]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, opb_q};
  assign q_bit    = ~rem_diff[33];

  assign last_o = (cnt_q == ((op_q == OP_DIV) ? 6'(N_DIV - 1) : 6'(N_MUL - 1)));
  assign res_o  = acc_q;

  // Next-state for the shared multiply/divide datapath.
  always_comb begin
    op_d  = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    rem_d = rem_q;
    if (load_i) begin
      op_d  = op_i;
      cnt_d = 6'd0;
      acc_d = 64'd0;
      rem_d = 32'd0;
      opb_d = b_i;
      opa_d = (op_i == OP_DIV) ? {16'd0, a_i, 16'd0} : {32'd0, a_i};
    end else if (step_i) begin
      cnt_d = cnt_q + 6'd1;
      if (op_q == OP_MUL) begin
        if (opb_q[0])
          acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        rem_d = q_bit ? rem_diff[31:0] : rem_sh[31:0];
        acc_d = {acc_q[62:0], q_bit};
        opa_d = opa_q << 1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 1'b0;
      cnt_q <= 6'd0;
      acc_q <= 64'd0;
      opa_q <= 64'd0;
      opb_q <= 32'd0;
      rem_q <= 32'd0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/polar_arith.sv
// Polar-domain complex multiply/divide: modulus through seq_muldiv, angle by
// add/sub with wrap into [-180,180). Start/done handshake, multi-cycle.
module polar_arith
  import polar_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  polar_arith_if.slave  bus
);

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             divz_q, divz_d;
  logic [ANG_W-1:0] ang_res_q, ang_res_d;  // wrapped angle, waits for done
  logic             done_q, done_d;
  logic [MOD_W-1:0] mod_out_q, mod_out_d;
  logic [ANG_W-1:0] ang_out_q, ang_out_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             md_load;
  logic             md_step;
  logic             md_last;
  logic [63:0]      md_res;
  logic signed [ANG_W:0] ang_sum;

  seq_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load_i (md_load),
    .step_i (md_step),
    .op_i   (bus.op),
    .a_i    (bus.mod_a),
    .b_i    (bus.mod_b),
    .last_o (md_last),
    .res_o  (md_res)
  );

  // Unwrapped angle sum/difference with one guard bit.
  assign ang_sum = (bus.op == OP_DIV)
                 ? ($signed({bus.ang_a[ANG_W-1], bus.ang_a}) - $signed({bus.ang_b[ANG_W-1], bus.ang_b}))
                 : ($signed({bus.ang_a[ANG_W-1], bus.ang_a}) + $signed({bus.ang_b[ANG_W-1], bus.ang_b}));

  // Control FSM and result formatting.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    divz_d    = divz_q;
    ang_res_d = ang_res_q;
    done_d    = 1'b0;
    mod_out_d = mod_out_q;
    ang_out_d = ang_out_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    md_load   = 1'b0;
    md_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          md_load   = 1'b1;
          op_d      = bus.op;
          divz_d    = (bus.op == OP_DIV) && (bus.mod_b == '0);
          ang_res_d = ang_wrap(ang_sum);
          ovf_d     = 1'b0;
          dz_d      = 1'b0;
          state_d   = ((bus.op == OP_DIV) && (bus.mod_b == '0)) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        md_step = 1'b1;
        if (md_last)
          state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        ang_out_d = ang_res_q;
        if (divz_q) begin
          mod_out_d = '1;
          dz_d      = 1'b1;
          ovf_d     = 1'b0;
        end else if (op_q == OP_MUL) begin
          if (md_res[63:48] != 16'd0) begin
            mod_out_d = '1;
            ovf_d     = 1'b1;
          end else begin
            mod_out_d = md_res[47:16];
          end
        end else begin
          if (md_res[47:32] != 16'd0) begin
            mod_out_d = '1;
            ovf_d     = 1'b1;
          end else begin
            mod_out_d = md_res[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      divz_q    <= 1'b0;
      ang_res_q <= '0;
      done_q    <= 1'b0;
      mod_out_q <= '0;
      ang_out_q <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      divz_q    <= divz_d;
      ang_res_q <= ang_res_d;
      done_q    <= done_d;
      mod_out_q <= mod_out_d;
      ang_out_q <= ang_out_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.mod_out  = mod_out_q;
  assign bus.ang_out  = ang_out_q;
  assign bus.ovf      = ovf_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_polar_arith.sv
// Scoreboard bench for polar_arith: the driver queues expected results, a
// monitor pops and compares whenever done is seen.
module tb_polar_arith;
  import polar_arith_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  polar_arith_if bus();

  polar_arith dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] mod;
    logic [31:0] ang;
    logic        ovf;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] deg(input int d);
    return 32'(d * (1 << ANG_FRAC));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn %s: mod=%h ang=%h ovf=%b dz=%b cyc=%0d", mon_e.name,
                 bus.mod_out, bus.ang_out, bus.ovf, bus.div_zero, cyc);
        chk({mon_e.name, "_mod"}, 64'(bus.mod_out), 64'(mon_e.mod));
        chk({mon_e.name, "_ang"}, 64'(bus.ang_out), 64'(mon_e.ang));
        chk({mon_e.name, "_ovf"}, 64'(bus.ovf), 64'(mon_e.ovf));
        chk({mon_e.name, "_dz"}, 64'(bus.div_zero), 64'(mon_e.dz));
        chk({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
        chk({mon_e.name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      end
    end
  end

  // Present one request at a negedge; returns the cycle stamp of the start edge.
  task automatic issue(input string nm, input logic op,
                       input logic [31:0] ma, input int aa,
                       input logic [31:0] mb, input int ab,
                       input logic [31:0] emod, input int eang,
                       input logic eovf, input logic edz, input int lat,
                       input bit hold, output int e0);
    int w;
    exp_t e;
    w = 0;
    while (bus.busy === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.op    = op;
    bus.mod_a = ma;
    bus.ang_a = deg(aa);
    bus.mod_b = mb;
    bus.ang_b = deg(ab);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    chk({nm, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    e.name = nm;
    e.mod  = emod;
    e.ang  = deg(eang);
    e.ovf  = eovf;
    e.dz   = edz;
    e.cyc  = e0 + lat;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e0;
    exp_t e;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.mod_a = '0;
    bus.ang_a = '0;
    bus.mod_b = '0;
    bus.ang_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mod", 64'(bus.mod_out), 64'd0);
    chk("rst_ang", 64'(bus.ang_out), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);

    // Directed vectors with hand-computed results.
    issue("mul_basic", OP_MUL, 32'h0002_0000, 100, 32'h0003_8000, 100,
          32'h0007_0000, -160, 1'b0, 1'b0, 33, 1'b0, e0);
    drain("mul_basic");
    issue("div_basic", OP_DIV, 32'h0007_0000, 30, 32'h0002_0000, -170,
          32'h0003_8000, -160, 1'b0, 1'b0, 49, 1'b0, e0);
    drain("div_basic");
    issue("div_zero", OP_DIV, 32'h0001_0000, 10, 32'h0000_0000, 20,
          32'hFFFF_FFFF, -10, 1'b0, 1'b1, 1, 1'b0, e0);
    drain("div_zero");
    issue("mul_ovf", OP_MUL, 32'h0100_0000, 0, 32'h0100_0000, 0,
          32'hFFFF_FFFF, 0, 1'b1, 1'b0, 33, 1'b0, e0);
    drain("mul_ovf");
    issue("mul_one", OP_MUL, 32'h0001_0000, -90, 32'h0001_0000, -90,
          32'h0001_0000, -180, 1'b0, 1'b0, 33, 1'b0, e0);
    drain("mul_one");
    issue("mul_zero", OP_MUL, 32'h0000_0000, 90, 32'h0005_0000, 90,
          32'h0000_0000, -180, 1'b0, 1'b0, 33, 1'b0, e0);
    drain("mul_zero");
    issue("div_ovf", OP_DIV, 32'h0100_0000, 0, 32'h0000_0001, -180,
          32'hFFFF_FFFF, -180, 1'b1, 1'b0, 49, 1'b0, e0);
    drain("div_ovf");
    issue("div_third", OP_DIV, 32'h0001_0000, -100, 32'h0003_0000, 100,
          32'h0000_5555, 160, 1'b0, 1'b0, 49, 1'b0, e0);
    drain("div_third");

    // Start held high: one op per accept, re-accept on the done cycle,
    // starts seen while busy are ignored.
    issue("hold_1", OP_MUL, 32'h0002_0000, 100, 32'h0003_8000, 100,
          32'h0007_0000, -160, 1'b0, 1'b0, 33, 1'b1, e0);
    e.name = "hold_2";
    e.mod  = 32'h0007_0000;
    e.ang  = deg(-160);
    e.ovf  = 1'b0;
    e.dz   = 1'b0;
    e.cyc  = e0 + 34 + 33;
    sb.push_back(e);
    while (cyc < e0 + 40) @(negedge clk);
    bus.start = 1'b0;
    drain("hold");
    repeat (40) @(negedge clk);

    // Asynchronous reset during iteration 10 aborts the operation.
    issue("abort", OP_MUL, 32'h0002_0000, 10, 32'h0002_0000, 10,
          32'h0004_0000, 20, 1'b0, 1'b0, 33, 1'b0, e0);
    while (cyc < e0 + 10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_mod", 64'(bus.mod_out), 64'd0);
    chk("abort_ang", 64'(bus.ang_out), 64'd0);
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    chk("abort_dz", 64'(bus.div_zero), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("after_abort", OP_MUL, 32'h0001_0000, 10, 32'h0001_0000, 20,
          32'h0001_0000, 30, 1'b0, 1'b0, 33, 1'b0, e0);
    drain("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
